// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C register-port target.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_REG_PTR,
      ST_PTR_ACK,
      ST_WRITE_DATA,
      ST_WRITE_ACK,
      ST_READ_DATA,
      ST_READ_ACK,
      ST_WAIT_STOP
   } i2c_target_state_t;

   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;
   localparam logic I2C_ACK   = 1'b0;
   localparam logic I2C_NACK  = 1'b1;

endpackage

// File: rtl/i2c_bus_conditioner.sv
// Synchronises SCL/SDA and produces registered SCL edge and START/STOP pulses.
module i2c_bus_conditioner (
   input  logic clock,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic sda_level_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_hist_q;
   logic       sda_hist_q;
   logic       scl_rise_q;
   logic       scl_fall_q;
   logic       start_q;
   logic       stop_q;
   logic       sda_level_q;

   // Idle bus level is high on both lines, so reset to 1 to avoid false edges.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scl_sync_q  <= 2'b11;
         sda_sync_q  <= 2'b11;
         scl_hist_q  <= 1'b1;
         sda_hist_q  <= 1'b1;
         scl_rise_q  <= 1'b0;
         scl_fall_q  <= 1'b0;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         sda_level_q <= 1'b1;
      end else begin
         scl_sync_q  <= {scl_sync_q[0], scl_i};
         sda_sync_q  <= {sda_sync_q[0], sda_i};
         scl_hist_q  <= scl_sync_q[1];
         sda_hist_q  <= sda_sync_q[1];
         scl_rise_q  <= scl_sync_q[1] & ~scl_hist_q;
         scl_fall_q  <= ~scl_sync_q[1] & scl_hist_q;
         start_q     <= scl_sync_q[1] & scl_hist_q & ~sda_sync_q[1] & sda_hist_q;
         stop_q      <= scl_sync_q[1] & scl_hist_q & sda_sync_q[1] & ~sda_hist_q;
         sda_level_q <= sda_sync_q[1];
      end
   end

   assign scl_rise_o  = scl_rise_q;
   assign scl_fall_o  = scl_fall_q;
   assign start_o     = start_q;
   assign stop_o      = stop_q;
   assign sda_level_o = sda_level_q;

endmodule

// File: rtl/i2c_target_register_port.sv
// Oversampled I2C target exposing a register-file strobe interface
// ([addr+W][ptr][data...] writes, [addr+W][ptr] Sr [addr+R][data...] reads).
module i2c_target_register_port
   import i2c_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned REGISTER_WIDTH = 8,
   parameter int unsigned ADDRESS_WIDTH  = 7
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      external_serial_clock,
   inout  wire                       external_serial_data,
   input  logic [ADDRESS_WIDTH-1:0]  device_address,
   output logic [REGISTER_WIDTH-1:0] reg_address,
   output logic [DATA_WIDTH-1:0]     reg_write_data,
   output logic                      reg_write_strobe,
   output logic                      reg_read_strobe,
   input  logic [DATA_WIDTH-1:0]     reg_read_data,
   output logic                      busy
);

   localparam int unsigned ADDR_FRAME = ADDRESS_WIDTH + 1;
   localparam int unsigned MAX_AP     = (ADDR_FRAME > REGISTER_WIDTH) ? ADDR_FRAME : REGISTER_WIDTH;
   localparam int unsigned SHIFT_W    = (MAX_AP > DATA_WIDTH) ? MAX_AP : DATA_WIDTH;
   localparam int unsigned CNT_W      = $clog2(SHIFT_W + 1);

   logic scl_rise, scl_fall, start_pulse, stop_pulse, sda_level;

   i2c_bus_conditioner u_cond (
      .clock       (clock),
      .reset       (reset),
      .scl_i       (external_serial_clock),
      .sda_i       (external_serial_data),
      .scl_rise_o  (scl_rise),
      .scl_fall_o  (scl_fall),
      .start_o     (start_pulse),
      .stop_o      (stop_pulse),
      .sda_level_o (sda_level)
   );

   i2c_target_state_t         state_q, state_d;
   logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
   logic [SHIFT_W-1:0]        shift_q, shift_d;
   logic [DATA_WIDTH-1:0]     tx_q, tx_d;
   logic [REGISTER_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      wstrobe_q, wstrobe_d;
   logic                      rstrobe_q, rstrobe_d;
   logic                      capture_q, capture_d;
   logic                      busy_q, busy_d;
   logic                      sda_low_q, sda_low_d;
   logic                      rw_q, rw_d;
   logic [SHIFT_W-1:0]        shifted_c;

   assign shifted_c = {shift_q[SHIFT_W-2:0], sda_level};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= '0;
         reg_addr_q <= '0;
         wdata_q    <= '0;
         wstrobe_q  <= 1'b0;
         rstrobe_q  <= 1'b0;
         capture_q  <= 1'b0;
         busy_q     <= 1'b0;
         sda_low_q  <= 1'b0;
         rw_q       <= I2C_WRITE;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         reg_addr_q <= reg_addr_d;
         wdata_q    <= wdata_d;
         wstrobe_q  <= wstrobe_d;
         rstrobe_q  <= rstrobe_d;
         capture_q  <= capture_d;
         busy_q     <= busy_d;
         sda_low_q  <= sda_low_d;
         rw_q       <= rw_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      reg_addr_d = reg_addr_q;
      wdata_d    = wdata_q;
      wstrobe_d  = 1'b0;
      rstrobe_d  = 1'b0;
      capture_d  = rstrobe_q;
      busy_d     = busy_q;
      sda_low_d  = sda_low_q;
      rw_d       = rw_q;

      // Pointer advances the clock after a write strobe; read data lands one clock after its strobe.
      if (wstrobe_q) reg_addr_d = reg_addr_q + REGISTER_WIDTH'(1);
      if (capture_q) tx_d = reg_read_data;

      if (stop_pulse) begin
         state_d   = ST_IDLE;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (start_pulse) begin
         state_d   = ST_ADDR;
         sda_low_d = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d = shifted_c;
                  if (bit_cnt_q == CNT_W'(ADDR_FRAME - 1)) begin
                     bit_cnt_d = '0;
                     if (shifted_c[ADDRESS_WIDTH:1] == device_address) begin
                        state_d = ST_ADDR_ACK;
                        busy_d  = 1'b1;
                        rw_d    = shifted_c[0];
                     end else begin
                        state_d = ST_WAIT_STOP;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            // First fall opens the ACK slot; a read leaves on the 9th rise so the
            // data path owns the fall that closes the slot.
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_low_q) begin
                     sda_low_d = 1'b1;
                  end else begin
                     sda_low_d = 1'b0;
                     state_d   = ST_REG_PTR;
                  end
               end else if (scl_rise && sda_low_q && rw_q == I2C_READ) begin
                  state_d   = ST_READ_DATA;
                  rstrobe_d = 1'b1;
                  bit_cnt_d = '0;
               end
            end
            ST_REG_PTR: begin
               if (scl_rise) begin
                  shift_d = shifted_c;
                  if (bit_cnt_q == CNT_W'(REGISTER_WIDTH - 1)) begin
                     bit_cnt_d  = '0;
                     reg_addr_d = shifted_c[REGISTER_WIDTH-1:0];
                     state_d    = ST_PTR_ACK;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_PTR_ACK, ST_WRITE_ACK: begin
               if (scl_fall) begin
                  if (!sda_low_q) begin
                     sda_low_d = 1'b1;
                  end else begin
                     sda_low_d = 1'b0;
                     state_d   = ST_WRITE_DATA;
                  end
               end
            end
            ST_WRITE_DATA: begin
               if (scl_rise) begin
                  shift_d = shifted_c;
                  if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                     bit_cnt_d = '0;
                     wdata_d   = shifted_c[DATA_WIDTH-1:0];
                     wstrobe_d = 1'b1;
                     state_d   = ST_WRITE_ACK;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_READ_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
                     sda_low_d = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = ST_READ_ACK;
                  end else begin
                     sda_low_d = ~tx_q[DATA_WIDTH-1];
                     tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_READ_ACK: begin
               if (scl_rise) begin
                  if (sda_level == I2C_ACK) begin
                     reg_addr_d = reg_addr_q + REGISTER_WIDTH'(1);
                     rstrobe_d  = 1'b1;
                     bit_cnt_d  = '0;
                     state_d    = ST_READ_DATA;
                  end else begin
                     state_d = ST_WAIT_STOP;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign external_serial_data = sda_low_q ? 1'b0 : 1'bz;
   assign reg_address          = reg_addr_q;
   assign reg_write_data       = wdata_q;
   assign reg_write_strobe     = wstrobe_q;
   assign reg_read_strobe      = rstrobe_q;
   assign busy                 = busy_q;

endmodule

// File: tb/tb_i2c_target_register_port.sv
// Directed bench: bit-banged I2C master, register-file model and strobe scoreboard.
module tb_i2c_target_register_port;

   localparam int Q = 6;

   logic       clock = 1'b0;
   logic       reset;
   logic       scl;
   logic       m_sda_low;
   logic [6:0] device_address;
   logic [7:0] reg_address, reg_write_data, reg_read_data;
   logic       reg_write_strobe, reg_read_strobe, busy;
   wire        sda;

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int rd_count = 0;
   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];

   always #5 clock = ~clock;

   i2c_target_register_port dut (
      .clock                 (clock),
      .reset                 (reset),
      .external_serial_clock (scl),
      .external_serial_data  (sda),
      .device_address        (device_address),
      .reg_address           (reg_address),
      .reg_write_data        (reg_write_data),
      .reg_write_strobe      (reg_write_strobe),
      .reg_read_strobe       (reg_read_strobe),
      .reg_read_data         (reg_read_data),
      .busy                  (busy)
   );

   // Register-file model: returns twice the requested address one clock after the strobe.
   always @(posedge clock) if (reg_read_strobe) reg_read_data <= {reg_address[6:0], 1'b0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && reg_read_strobe) rd_count++;
      if (!reset && reg_write_strobe) begin
         wr_count++;
         if (exp_wr.size() == 0) chk("wr_unexpected", 32'(exp_wr.size()), 32'd1);
         else chk("wr_strobe", {16'd0, reg_address, reg_write_data}, {16'd0, exp_wr.pop_front()});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b; tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0; tick(Q);
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); b = sda; tick(Q); scl = 1'b0; tick(Q);
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_sda_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_sda_low = 1'b0; tick(2 * Q);
   endtask

   task automatic wr_byte(input string tag, input logic [7:0] d, input logic exp_ack);
      logic a;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(a);
      chk(tag, {31'd0, a}, {31'd0, exp_ack});
   endtask

   task automatic rd_byte(input string tag, input logic ack);
      logic [7:0] d;
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(ack);
      chk(tag, {24'd0, d}, {24'd0, exp_rd.pop_front()});
   endtask

   initial begin
      int rd0;
      reset = 1'b1; scl = 1'b1; m_sda_low = 1'b0; device_address = 7'h68;
      tick(5); reset = 1'b0; tick(5);

      chk("rst_sda", {31'd0, sda}, 32'd1);
      chk("rst_addr", {24'd0, reg_address}, 32'd0);
      chk("rst_wdata", {24'd0, reg_write_data}, 32'd0);
      chk("rst_strobes", {30'd0, reg_write_strobe, reg_read_strobe}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // Single register write
      bus_start();
      wr_byte("w1_addr_ack", 8'hD0, 1'b0);
      chk("w1_busy", {31'd0, busy}, 32'd1);
      exp_wr.push_back({8'h6B, 8'h80});
      wr_byte("w1_ptr_ack", 8'h6B, 1'b0);
      wr_byte("w1_data_ack", 8'h80, 1'b0);
      bus_stop(); tick(4);
      chk("w1_busy_clr", {31'd0, busy}, 32'd0);
      chk("w1_addr_inc", {24'd0, reg_address}, 32'h6C);
      chk("w1_count", 32'(wr_count), 32'd1);

      // Burst write
      bus_start();
      wr_byte("w2_addr_ack", 8'hD0, 1'b0);
      exp_wr.push_back({8'h1A, 8'h00});
      exp_wr.push_back({8'h1B, 8'h18});
      exp_wr.push_back({8'h1C, 8'h10});
      wr_byte("w2_ptr_ack", 8'h1A, 1'b0);
      wr_byte("w2_d0_ack", 8'h00, 1'b0);
      wr_byte("w2_d1_ack", 8'h18, 1'b0);
      wr_byte("w2_d2_ack", 8'h10, 1'b0);
      chk("w2_busy", {31'd0, busy}, 32'd1);
      bus_stop(); tick(4);
      chk("w2_busy_clr", {31'd0, busy}, 32'd0);
      chk("w2_count", 32'(wr_count), 32'd4);

      // Pointer write, repeated START, two-byte read
      rd0 = rd_count;
      bus_start();
      wr_byte("r_addrw_ack", 8'hD0, 1'b0);
      wr_byte("r_ptr_ack", 8'h43, 1'b0);
      bus_start();
      wr_byte("r_addrr_ack", 8'hD1, 1'b0);
      exp_rd.push_back(8'h86);
      exp_rd.push_back(8'h88);
      rd_byte("r_byte0", 1'b0);
      rd_byte("r_byte1", 1'b1);
      bus_stop(); tick(4);
      chk("r_strobes", 32'(rd_count - rd0), 32'd2);
      chk("r_addr", {24'd0, reg_address}, 32'h44);
      chk("r_busy_clr", {31'd0, busy}, 32'd0);

      // Foreign address is NACKed and ignored
      bus_start();
      wr_byte("n_addr_nack", 8'hD2, 1'b1);
      chk("n_busy", {31'd0, busy}, 32'd0);
      wr_byte("n_data_nack", 8'h00, 1'b1);
      bus_stop(); tick(4);
      chk("n_busy_after", {31'd0, busy}, 32'd0);
      chk("n_count", 32'(wr_count), 32'd4);

      // Pointer wrap 0xFF -> 0x00
      bus_start();
      wr_byte("wr_addr_ack", 8'hD0, 1'b0);
      exp_wr.push_back({8'hFF, 8'h11});
      exp_wr.push_back({8'h00, 8'h22});
      wr_byte("wr_ptr_ack", 8'hFF, 1'b0);
      wr_byte("wr_d0_ack", 8'h11, 1'b0);
      wr_byte("wr_d1_ack", 8'h22, 1'b0);
      bus_stop(); tick(4);
      chk("wr_count", 32'(wr_count), 32'd6);
      chk("wr_addr", {24'd0, reg_address}, 32'h01);

      // Reset while the target drives a 0 data bit (0x10 -> model byte 0x20)
      bus_start();
      wr_byte("x_addrw_ack", 8'hD0, 1'b0);
      wr_byte("x_ptr_ack", 8'h10, 1'b0);
      bus_start();
      wr_byte("x_addrr_ack", 8'hD1, 1'b0);
      chk("x_sda_driven", {31'd0, sda}, 32'd0);
      reset = 1'b1;
      #1;
      chk("x_sda_released", {31'd0, sda}, 32'd1);
      chk("x_busy", {31'd0, busy}, 32'd0);
      tick(3); reset = 1'b0; tick(3);
      bus_stop(); tick(4);
      bus_start();
      wr_byte("x2_addr_ack", 8'hD0, 1'b0);
      exp_wr.push_back({8'h20, 8'h55});
      wr_byte("x2_ptr_ack", 8'h20, 1'b0);
      wr_byte("x2_data_ack", 8'h55, 1'b0);
      bus_stop(); tick(4);
      chk("x2_count", 32'(wr_count), 32'd7);
      chk("x2_addr", {24'd0, reg_address}, 32'h21);
      chk("queue_empty", 32'(exp_wr.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      chk("timeout", 32'd1, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_target_register_port.md
Name: i2c_target_register_port

Overview:
- Clock-oversampled I2C target (slave) that answers the MPU6050-style register protocol our I2C master issues.
- Write transaction: [addr+W][reg pointer][data...].
- Read transaction: [addr+W][reg pointer], repeated START, [addr+R][data...].
- Register storage is external. The block exposes a simple register-file strobe interface.
- Used as the bench-side device model for the I2C master, and as an on-chip configuration port.

Parameters:
- DATA_WIDTH, 8, width of data bytes and of the register-file data bus.
- REGISTER_WIDTH, 8, width of the register pointer.
- ADDRESS_WIDTH, 7, width of the I2C device address.

Ports:
- clock  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- external_serial_clock  input  1  SCL from the bus. The block never drives it; no clock stretching.
- external_serial_data  inout  1  SDA, open-drain. The block drives 0 or Z only.
- device_address  input  ADDRESS_WIDTH  address this target responds to; quasi-static.
- reg_address  output  REGISTER_WIDTH  current register pointer.
- reg_write_data  output  DATA_WIDTH  byte received from the master.
- reg_write_strobe  output  1  one-clock pulse: write reg_write_data to reg_address.
- reg_read_strobe  output  1  one-clock pulse: reg_read_data is requested for reg_address.
- reg_read_data  input  DATA_WIDTH  must be valid exactly 1 clock after reg_read_strobe.
- busy  output  1  high from address match until STOP.

Behaviour:
- Reset values of outputs and drivers:
  - SDA released (Z); reg_address=0; reg_write_data=0.
  - Both strobes 0; busy=0; state IDLE.
  - Assertion mid-transaction releases SDA within the same cycle and abandons the transfer.
- Input conditioning and bus events:
  - SCL and SDA each pass through a 2-flop synchroniser plus a history flop.
  - Edges are detected on the synchronised signals, giving 3 clocks of detection latency.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - START and STOP take priority over bit processing in the same clock.
  - Data bits are sampled on the SCL rising edge.
  - SDA drive changes only on the SCL falling edge.
- State machine:
  - IDLE: on START go to ADDR.
  - ADDR: shift 8 bits, MSB first.
    - Upper 7 bits equal device_address: go to ADDR_ACK and set busy.
    - Otherwise: go to WAIT_STOP with SDA released (NACK).
  - ADDR_ACK: drive SDA low from the falling edge after bit 8 to the falling edge after bit 9.
    - R/W=0: go to REG_PTR.
    - R/W=1: go to READ_DATA.
  - REG_PTR: shift 8 bits, load reg_address on bit 8, then go to PTR_ACK (ACK always).
  - PTR_ACK: then go to WRITE_DATA.
  - WRITE_DATA: shift 8 bits. On the 8th rising edge:
    - reg_write_data <= byte and pulse reg_write_strobe.
    - reg_address increments on the following clock.
    - Go to WRITE_ACK (ACK always), then back to WRITE_DATA.
  - READ_DATA:
    - On entry, pulse reg_read_strobe and capture reg_read_data one clock later.
    - Drive the MSB at the SCL falling edge that ends the ACK slot, then shift out on each falling edge.
    - Bit value 1 means SDA released.
    - After bit 8, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on the 9th rising edge.
    - ACK (0): increment reg_address, then go to READ_DATA.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Global transitions, from any non-IDLE state:
  - STOP goes to IDLE, releases SDA and clears busy.
  - Repeated START goes to ADDR with reg_address preserved.
- Boundary rules:
  - reg_address wraps 0xFF->0x00.
  - STOP during a partial byte discards the byte; no strobe is issued.
  - A START/STOP glitch while SCL is low is ignored.
  - No general-call support.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum typedef (i2c_target_state_t);
  - the R/W bit encoding constants (I2C_WRITE=0, I2C_READ=1);
  - an ACK/NACK constant.
- One sub-module, i2c_bus_conditioner: synchronisers, SCL rise/fall pulses, start/stop pulses.

Test Plan:
- Write: device_address=0x68; master writes 0x6B,0x80 -> ACK on all 3 bytes; reg_write_strobe once with reg_address=0x6B and data 0x80; reg_address becomes 0x6C.
- Burst write: 0x1A,0x00,0x18,0x10 -> 3 strobes at addresses 0x1A,0x1B,0x1C; STOP clears busy.
- Read: write pointer 0x43, repeated START, addr+R; model returns 0x43+addr -> master receives 0x86; ACK then NACK -> second byte 0x88 from 0x44; STOP -> IDLE.
- Address 0x69 while device_address=0x68 -> NACK, no strobes, busy stays 0 until after STOP.
- Pointer 0xFF, two-byte burst write -> strobes at 0xFF then 0x00.
- reset asserted mid read-byte while the block drives SDA low -> SDA Z within 1 clock; next full write transaction succeeds.
